// File: rtl/block_plotter.sv
// Rectangle plotter: streams a BLK_W x BLK_H block (filled/outline/erase, edge-clipped) to the VGA pixel port.
// Latency: first pixel one cycle after the start edge is taken, one pixel per clock, done one cycle after the last pixel.
// Backpressure: none; start is honoured only when idle and dropped while busy.
module block_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int BLK_W    = 4,
    parameter int BLK_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] colour_in,
    input  logic           erase,
    input  logic           outline,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [X_W-1:0] CX_LAST = X_W'(BLK_W - 1);
    localparam logic [Y_W-1:0] CY_LAST = Y_W'(BLK_H - 1);
    localparam logic [X_W:0]   SCR_W   = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SCR_H   = (Y_W+1)'(SCREEN_H);

    state_t         state;
    logic [X_W-1:0] x0;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] cy;
    logic [C_W-1:0] col;
    logic           outl;

    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic           last_col;
    logic           last_row;
    logic           on_border;
    logic           in_screen;

    // One extra sum bit keeps blocks past the right/bottom edge from wrapping onto column/row 0.
    assign x_sum     = {1'b0, x0} + {1'b0, cx};
    assign y_sum     = {1'b0, y0} + {1'b0, cy};
    assign last_col  = (cx == CX_LAST);
    assign last_row  = (cy == CY_LAST);
    assign on_border = (cx == '0) || last_col || (cy == '0) || last_row;
    assign in_screen = (x_sum < SCR_W) && (y_sum < SCR_H);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x0         <= '0;
            y0         <= '0;
            cx         <= '0;
            cy         <= '0;
            col        <= '0;
            outl       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        x0    <= x_in;
                        y0    <= y_in;
                        col   <= erase ? BG_COLOUR : colour_in;
                        outl  <= outline;
                        cx    <= '0;
                        cy    <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    x_out      <= x_sum[X_W-1:0];
                    y_out      <= y_sum[Y_W-1:0];
                    colour_out <= col;
                    plot       <= in_screen && (!outl || on_border);
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    // Suppressed pixels still advance the sweep so its length never varies.
                    if (last_col) begin
                        cx <= '0;
                        if (last_row) begin
                            cy    <= '0;
                            state <= DONE;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DONE: begin
                    plot  <= 1'b0;
                    busy  <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_plotter.sv
// Bench for block_plotter: per-edge expectations from a sweep model, plus literal checks on directed requests.
module tb_block_plotter;
    localparam int BW   = 4;
    localparam int BH   = 4;
    localparam int T    = BW * BH;
    localparam int MAXE = 8000;

    logic       clk = 1'b0;
    logic       reset, start, erase, outline;
    logic [7:0] x_in, x_out;
    logic [6:0] y_in, y_out;
    logic [2:0] colour_in, colour_out;
    logic       plot, busy, done;

    block_plotter dut (
        .clk(clk), .reset(reset), .start(start),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .erase(erase), .outline(outline),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int next_free = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int last_done = -1;

    // Expected outputs indexed by the posedge after which they must be visible.
    bit       e_busy [MAXE];
    bit       e_done [MAXE];
    bit       e_plot [MAXE];
    bit       e_pv   [MAXE];
    bit [7:0] e_x    [MAXE];
    bit [6:0] e_y    [MAXE];
    bit [2:0] e_c    [MAXE];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int e, input bit st, input bit rst, input int x, input int y,
                              input int c, input bit er, input bit ol);
        if (rst) begin
            for (int i = e; i <= e + T + 1; i++) begin
                e_busy[i] = 0; e_done[i] = 0; e_plot[i] = 0; e_pv[i] = 0;
            end
            e_pv[e] = 1; e_x[e] = 0; e_y[e] = 0; e_c[e] = 0;
            next_free = e + 1;
        end else if (st && e >= next_free) begin
            for (int k = 0; k < T; k++) begin
                int cx, cy, xs, ys, idx;
                bit border;
                cx = k % BW; cy = k / BW;
                xs = x + cx; ys = y + cy;
                idx = e + 1 + k;
                border = (cx == 0) || (cx == BW - 1) || (cy == 0) || (cy == BH - 1);
                e_plot[idx] = (xs < 160) && (ys < 120) && (!ol || border);
                e_busy[idx] = 1; e_done[idx] = 0; e_pv[idx] = 1;
                e_x[idx] = 8'(xs); e_y[idx] = 7'(ys); e_c[idx] = er ? 3'b000 : 3'(c);
            end
            e_busy[e + T + 1] = 1; e_done[e + T + 1] = 1; e_plot[e + T + 1] = 0; e_pv[e + T + 1] = 0;
            next_free = e + T + 2;
        end
    endtask

    task automatic check();
        cmp("busy", busy, e_busy[cyc]);
        cmp("done", done, e_done[cyc]);
        cmp("plot", plot, e_plot[cyc]);
        if (e_pv[cyc]) begin
            cmp("x_out", x_out, e_x[cyc]);
            cmp("y_out", y_out, e_y[cyc]);
            cmp("colour_out", colour_out, e_c[cyc]);
        end
        if (plot === 1'b1) plot_cnt++;
        if (done === 1'b1) begin done_cnt++; last_done = cyc; end
    endtask

    task automatic step(input bit st, input bit rst, input int x, input int y, input int c,
                        input bit er, input bit ol);
        start = st; reset = rst;
        x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c); erase = er; outline = ol;
        model_edge(cyc + 1, st, rst, x, y, c, er, ol);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic req(input int x, input int y, input int c, input bit er, input bit ol, output int n);
        plot_cnt = 0; done_cnt = 0; last_done = -1;
        n = cyc + 1;
        step(1, 0, x, y, c, er, ol);
    endtask

    initial begin
        int n, n2;
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        cmp("reset_busy", busy, 0);
        cmp("reset_x", x_out, 0);
        idle(2);

        // Filled 4x4 at (10,20)
        req(10, 20, 3'b100, 0, 0, n);
        idle(1);
        cmp("t1_first_x", x_out, 10);
        cmp("t1_first_y", y_out, 20);
        cmp("t1_first_colour", colour_out, 3'b100);
        idle(T - 1);
        cmp("t1_last_x", x_out, 13);
        cmp("t1_last_y", y_out, 23);
        idle(2);
        cmp("t1_plot_count", plot_cnt, 16);
        cmp("t1_done_count", done_cnt, 1);
        cmp("t1_done_edge", last_done, n + 17);

        // Outline: interior pixel (11,21) is pixel 5
        req(10, 20, 3'b100, 0, 1, n);
        idle(6);
        cmp("t2_inner_x", x_out, 11);
        cmp("t2_inner_y", y_out, 21);
        cmp("t2_inner_plot", plot, 0);
        idle(T - 4);
        cmp("t2_plot_count", plot_cnt, 12);
        cmp("t2_done_edge", last_done, n + 17);

        // Erase
        req(0, 0, 3'b111, 1, 0, n);
        idle(1);
        cmp("t3_colour", colour_out, 0);
        idle(T + 1);
        cmp("t3_plot_count", plot_cnt, 16);

        // Clip at bottom-right corner
        req(158, 118, 3'b010, 0, 0, n);
        idle(T + 2);
        cmp("t4_plot_count", plot_cnt, 4);
        cmp("t4_done_edge", last_done, n + 17);

        // Starts while busy are dropped; start at +18 is accepted
        req(30, 40, 3'b001, 0, 0, n);
        idle(2);
        step(1, 0, 90, 90, 3'b110, 0, 0);
        idle(13);
        step(1, 0, 90, 90, 3'b110, 0, 0);
        cmp("t5_done_count", done_cnt, 1);
        cmp("t5_done_edge", last_done, n + 17);
        n2 = cyc + 1;
        step(1, 0, 50, 60, 3'b011, 0, 0);
        cmp("t5_restart_edge", n2, n + 18);
        idle(T + 2);
        cmp("t5_total_done", done_cnt, 2);
        cmp("t5_second_done_edge", last_done, n2 + 17);
        cmp("t5_plot_count", plot_cnt, 32);

        // Reset during the 6th draw cycle
        req(20, 30, 3'b101, 0, 0, n);
        idle(5);
        step(0, 1, 0, 0, 0, 0, 0);
        cmp("t6_plot_after_reset", plot, 0);
        cmp("t6_busy_after_reset", busy, 0);
        idle(T + 4);
        cmp("t6_no_done", done_cnt, 0);
        req(0, 0, 3'b110, 0, 0, n);
        idle(T + 2);
        cmp("t6_fresh_plot_count", plot_cnt, 16);
        cmp("t6_fresh_done_edge", last_done, n + 17);

        // Random traffic including off-screen origins, busy starts and stray resets
        for (int i = 0; i < 2500; i++) begin
            step(($urandom % 4) == 0, ($urandom % 60) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle(T + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
